key_led_ctrl: RTL and testbench
===============================

KEY_LED_CTRL -- requirements
Module: key_led_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CNT, default 1_000_000, meaning clock cycles the key must hold stable (20 ms at 50 MHz).
REQ-002 SHALL have parameter LONG_CNT, default 50_000_000, meaning clock cycles held pressed before a long-press event (1 s at 50 MHz).
REQ-003 SHALL have port sys_clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port sys_rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port key  input  1  raw asynchronous push-button; idle high, pressed low.
REQ-006 SHALL have port key_value  output  1  debounced key level; 1 = released, 0 = pressed.
REQ-007 SHALL have port key_flag  output  1  one-cycle pulse on each debounced press.
REQ-008 SHALL have port long_flag  output  1  one-cycle pulse on long press; tied 0 when feature is absent.
REQ-009 SHALL have port led  output  1  LED drive; high = lit.

Function
REQ-010 SHALL pass key through a 2-flop synchronizer, reset value 1; synchronized signal is key_s.
REQ-011 SHALL implement FSM states IDLE, PRESS_FILT, HELD, RELEASE_FILT.
- IDLE: key_s=0 -> PRESS_FILT, counter cleared.
- PRESS_FILT: key_s=1 -> IDLE; counter reaching DEBOUNCE_CNT-1 with key_s=0 -> HELD.
- HELD: key_s=1 -> RELEASE_FILT, counter cleared.
- RELEASE_FILT: key_s=0 -> HELD; counter reaching DEBOUNCE_CNT-1 with key_s=1 -> IDLE.
REQ-012 SHALL restart the debounce counter from 0 on any key_s level change during a filter state; a glitch shorter than DEBOUNCE_CNT cycles SHALL produce no event.
REQ-013 SHALL size the debounce counter as $clog2(DEBOUNCE_CNT) bits, saturating, with no wrap-around.
REQ-014 SHALL assert key_flag for exactly one cycle, the cycle after PRESS_FILT->HELD; key_value SHALL go 0 in that same cycle.
REQ-015 SHALL return key_value to 1 the cycle after RELEASE_FILT->IDLE; release SHALL produce no pulse.
REQ-016 SHALL toggle led on each key_flag; led SHALL change in the cycle after key_flag.
REQ-017 SHALL produce at most one key_flag per press, regardless of hold time.
REQ-018 SHALL have a total latency from a stable key low to key_flag of 2 (sync) + DEBOUNCE_CNT + 1 cycles.

Reset
REQ-019 SHALL, with sys_rst_n=0 at a clock edge: FSM=IDLE, counters=0, sync flops=1, key_value=1, key_flag=0, long_flag=0, led=0.
REQ-020 SHALL, on reset mid-press, discard any in-progress filter or long count; a key still held after reset SHALL be re-debounced and SHALL produce a new key_flag.

Configuration
REQ-021 SHALL use macro KEY_LONG_PRESS_EN to compile in long-press detection.
- Defined: a second counter of $clog2(LONG_CNT) bits runs in HELD and RELEASE_FILT; at LONG_CNT-1 it pulses long_flag once and saturates; the counter clears on entry to IDLE; long_flag SHALL NOT toggle led.
- Undefined: no long counter exists; long_flag SHALL be constant 0.

Structure
REQ-022 SHALL take the FSM state enum (2-bit encoding) and the default DEBOUNCE_CNT/LONG_CNT constants from a shared package key_pkg.
REQ-023 SHALL place synchronizer plus debounce FSM in sub-module key_debounce (outputs key_value, key_flag); key_led_ctrl SHALL instantiate it and add the LED toggle and long-press logic.

Verification
REQ-024 SHALL be verified with DEBOUNCE_CNT=10, LONG_CNT=40 in the bench.
- Reset: hold sys_rst_n=0 for 3 cycles, key=1 -> key_value=1, led=0, both flags 0.
- Clean press: key=0 held 20 cycles -> single key_flag pulse 13 cycles after the key edge; led 0->1; key_value=0.
- Bounce: key toggled every 3 cycles for 30 cycles, then held 1 -> no key_flag; led stays 0.
- Two presses: press 20 cycles, release 20 cycles, press 20 cycles -> two key_flag pulses; led 0->1->0.
- Long press (macro on): key=0 held 60 cycles -> one key_flag then one long_flag 40 cycles after HELD entry; led toggles once only; macro off -> long_flag stays 0.
- Reset mid-press: key=0, reset at cycle 5 of filter, key still low -> key_flag at 13 cycles after reset release.

Source files
------------

// File: rtl/key_pkg.sv
// key_pkg: shared FSM state encoding, default timing constants and counter width helper
package key_pkg;
  typedef enum logic [1:0] {IDLE, PRESS_FILT, HELD, RELEASE_FILT} state_t;
  localparam int DEBOUNCE_CNT_DEF = 1_000_000;
  localparam int LONG_CNT_DEF = 50_000_000;
  function automatic int cw(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchronizer plus debounce FSM for an active-low push-button
//   sys_clk   : system clock, rising edge
//   sys_rst_n : synchronous active-low reset
//   key       : raw asynchronous key, idle high, pressed low
//   key_value : debounced level, 1 = released, 0 = pressed
//   key_flag  : one-cycle pulse on each debounced press
module key_debounce
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key,
  output logic key_value,
  output logic key_flag
);
  localparam int CW = cw(DEBOUNCE_CNT);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CNT - 1);
  logic [1:0] sync;
  logic key_s;
  state_t state;
  logic [CW-1:0] cnt;
  assign key_s = sync[1];
  // the counter only advances while below LAST, so it saturates instead of wrapping;
  // leaving a filter state always lands in a state whose exit clears it again
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      sync <= 2'b11;
      state <= IDLE;
      cnt <= '0;
      key_value <= 1'b1;
      key_flag <= 1'b0;
    end else begin
      sync <= {sync[0], key};
      key_flag <= 1'b0;
      case (state)
        IDLE: if (!key_s) begin
          state <= PRESS_FILT;
          cnt <= '0;
        end
        PRESS_FILT: if (key_s) state <= IDLE;
          else if (cnt == LAST) begin
            state <= HELD;
            key_value <= 1'b0;
            key_flag <= 1'b1;
          end else cnt <= cnt + 1'b1;
        HELD: if (key_s) begin
          state <= RELEASE_FILT;
          cnt <= '0;
        end
        RELEASE_FILT: if (!key_s) state <= HELD;
          else if (cnt == LAST) begin
            state <= IDLE;
            key_value <= 1'b1;
          end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/key_led_ctrl.sv
// key_led_ctrl: debounced key toggling an LED, with optional long-press detection
//   sys_clk   : system clock, rising edge
//   sys_rst_n : synchronous active-low reset
//   key       : raw asynchronous key, idle high, pressed low
//   key_value : debounced level, 1 = released, 0 = pressed
//   key_flag  : one-cycle pulse on each debounced press
//   long_flag : one-cycle pulse LONG_CNT cycles into a press (KEY_LONG_PRESS_EN), else 0
//   led       : LED drive, high = lit, toggles on every key_flag
// Macro KEY_LONG_PRESS_EN compiles in the long-press counter.
module key_led_ctrl
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEF,
  parameter int LONG_CNT = LONG_CNT_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key,
  output logic key_value,
  output logic key_flag,
  output logic long_flag,
  output logic led
);
  key_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_debounce (
    .sys_clk(sys_clk),
    .sys_rst_n(sys_rst_n),
    .key(key),
    .key_value(key_value),
    .key_flag(key_flag)
  );
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) led <= 1'b0;
    else led <= led ^ key_flag;
  end
`ifdef KEY_LONG_PRESS_EN
  localparam int LW = cw(LONG_CNT);
  localparam logic [LW-1:0] LLAST = LW'(LONG_CNT - 1);
  logic [LW-1:0] lcnt;
  logic fired;
  // key_value is low exactly while the FSM is in HELD or RELEASE_FILT;
  // fired keeps the saturated counter from pulsing again
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n || key_value) begin
      lcnt <= '0;
      fired <= 1'b0;
      long_flag <= 1'b0;
    end else begin
      long_flag <= (lcnt == LLAST) && !fired;
      fired <= fired | (lcnt == LLAST);
      if (lcnt != LLAST) lcnt <= lcnt + 1'b1;
    end
  end
`else
  assign long_flag = (LONG_CNT < 0);
`endif
endmodule

// File: tb/tb_key_led_ctrl.sv
// tb_key_led_ctrl: directed stimulus with an event scoreboard for key_led_ctrl
module tb_key_led_ctrl;
  localparam int D = 10;
  localparam int L = 40;
  localparam int LAT = 2 + D + 1;
  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic key = 1'b1;
  logic key_value, key_flag, long_flag, led;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {bit is_long; int at; bit led;} ev_t;
  ev_t q[$];
  bit exp_led = 1'b0;
  bit led_chk = 1'b0;
  bit led_want = 1'b0;
  int t;

  key_led_ctrl #(.DEBOUNCE_CNT(D), .LONG_CNT(L)) dut (
    .sys_clk(sys_clk),
    .sys_rst_n(sys_rst_n),
    .key(key),
    .key_value(key_value),
    .key_flag(key_flag),
    .long_flag(long_flag),
    .led(led)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic expect_press(input int at);
    exp_led = ~exp_led;
    q.push_back('{is_long: 1'b0, at: at, led: exp_led});
  endtask

  task automatic expect_long(input int at);
    q.push_back('{is_long: 1'b1, at: at, led: exp_led});
  endtask

  task automatic pop(input bit is_long);
    ev_t e;
    if (q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: unexpected pulse at cycle %0d, want none", is_long ? "long_flag" : "key_flag", cyc);
      return;
    end
    e = q.pop_front();
    check(is_long ? "long_kind" : "key_kind", 32'(is_long), 32'(e.is_long));
    check(is_long ? "long_cycle" : "key_cycle", cyc, e.at);
    if (!is_long) begin
      led_chk = 1'b1;
      led_want = e.led;
    end
  endtask

  always @(negedge sys_clk) begin
    if (led_chk) begin
      check("led_toggle", 32'(led), 32'(led_want));
      led_chk = 1'b0;
    end
    if (key_flag === 1'b1) pop(1'b0);
    if (long_flag === 1'b1) pop(1'b1);
  end

  initial begin
    tick(3);
    check("rst_key_value", 32'(key_value), 1);
    check("rst_led", 32'(led), 0);
    check("rst_key_flag", 32'(key_flag), 0);
    check("rst_long_flag", 32'(long_flag), 0);
    sys_rst_n = 1'b1;
    tick(5);
    key = 1'b0;
    t = cyc;
    expect_press(t + LAT);
    tick(LAT + 1);
    check("press_key_value", 32'(key_value), 0);
    tick(20 - LAT - 1);
    key = 1'b1;
    tick(30);
    check("release_key_value", 32'(key_value), 1);
    for (int i = 0; i < 10; i++) begin
      key = ~key;
      tick(3);
    end
    key = 1'b1;
    tick(30);
    check("bounce_led", 32'(led), 32'(exp_led));
    check("bounce_key_value", 32'(key_value), 1);
    repeat (2) begin
      key = 1'b0;
      t = cyc;
      expect_press(t + LAT);
      tick(20);
      key = 1'b1;
      tick(20);
    end
    check("two_press_led", 32'(led), 32'(exp_led));
    key = 1'b0;
    t = cyc;
    expect_press(t + LAT);
`ifdef KEY_LONG_PRESS_EN
    expect_long(t + LAT + L);
`endif
    tick(LAT + L + 2);
    check("long_led_once", 32'(led), 32'(exp_led));
`ifndef KEY_LONG_PRESS_EN
    check("long_flag_off", 32'(long_flag), 0);
`endif
    tick(60 - (LAT + L + 2));
    key = 1'b1;
    tick(30);
    key = 1'b0;
    tick(8);
    sys_rst_n = 1'b0;
    tick(1);
    check("midrst_led", 32'(led), 0);
    check("midrst_key_value", 32'(key_value), 1);
    sys_rst_n = 1'b1;
    exp_led = 1'b0;
    t = cyc;
    expect_press(t + LAT);
    tick(LAT + 5);
    key = 1'b1;
    tick(30);
    check("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
